// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the program-counter / instruction-fetch stage.
//   fetch_state_t      : fetch FSM state encoding
//   XLEN, INSTR_BYTES  : datapath width and instruction size in bytes
//   PC_STEP            : sequential PC increment at XLEN width
//   RESET_PC_DEFAULT   : default PC loaded on reset
//   TRAP_PC_DEFAULT    : default PC loaded on a misaligned taken target
//                        (only meaningful with PC_FETCH_MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_PC_DEFAULT  = 32'h0000_0100;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection.
//   pc        in  : current PC
//   pc_source in  : 1 = branch/jump taken, select target
//   target    in  : branch/jump target address
//   next_pc   out : PC to load when the current instruction retires
//   misalign  out : taken target has non-zero low bits (trap build only)
// Build option PC_FETCH_MISALIGN_TRAP_EN:
//   defined   : misaligned taken target redirects to TRAP_PC and flags misalign
//   undefined : low two target bits are cleared, misalign is always 0
// -----------------------------------------------------------------------------
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_PC = TRAP_PC_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_source,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    always_comb begin
        next_pc  = pc + PC_STEP;   // wraps modulo 2^32
        misalign = 1'b0;
        if (pc_source) begin
            if (target[1:0] != 2'b00) begin
                next_pc  = TRAP_PC;
                misalign = 1'b1;
            end else begin
                next_pc  = target;
            end
        end
    end
`else
    // TRAP_PC has no role in this build; the name keeps it out of lint.
    logic [XLEN-1:0] unused_trap_pc;
    assign unused_trap_pc = TRAP_PC;

    always_comb begin
        next_pc  = pc + PC_STEP;   // wraps modulo 2^32
        misalign = 1'b0;
        if (pc_source) begin
            next_pc = {target[XLEN-1:2], 2'b00};
        end
    end
`endif

endmodule : pc_next_sel

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Program counter and instruction fetch stage of the single-cycle core.
// Fetches one instruction over a req/gnt/rvalid handshake, presents it to
// decode and holds it until execute retires it, then advances the PC.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   pc_source_i, target_i : branch decision and target (valid with ack)
//   stall_i, instr_ack_i  : retire handshake from execute
//   imem_req_o/addr_o     : fetch request and address (addr == pc_o)
//   imem_gnt_i/rvalid_i/rdata_i : instruction memory response
//   instr_o, instr_valid_o: registered instruction and its valid flag
//   pc_o, pc_plus4_o      : current PC and PC + 4 (link value)
//   misalign_o            : one-cycle pulse after a misaligned taken retire
// Build option PC_FETCH_MISALIGN_TRAP_EN enables the misaligned-target trap
// (see pc_next_sel); without it misalign_o stays 0.
// -----------------------------------------------------------------------------
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_PC  = TRAP_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pc_source_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    input  logic        instr_ack_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misalign_o
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_next;
    logic         misalign_reg, misalign_next;

    logic [31:0]  sel_next_pc;
    logic         sel_misalign;

    pc_next_sel #(
        .TRAP_PC (TRAP_PC)
    ) u_pc_next_sel (
        .pc        (pc_reg),
        .pc_source (pc_source_i),
        .target    (target_i),
        .next_pc   (sel_next_pc),
        .misalign  (sel_misalign)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        misalign_next = 1'b0;   // pulse: only set on the retiring edge
        unique case (state_reg)
            S_REQ: begin
                if (imem_gnt_i && imem_rvalid_i) begin
                    instr_next = imem_rdata_i;
                    state_next = S_VALID;
                end else if (imem_gnt_i) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Request already accepted; a stray gnt here means nothing.
                if (imem_rvalid_i) begin
                    instr_next = imem_rdata_i;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (instr_ack_i && !stall_i) begin
                    pc_next       = sel_next_pc;
                    misalign_next = sel_misalign;
                    state_next    = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Request is gated by reset so memory sees no request while held in reset.
    assign imem_req_o    = (state_reg == S_REQ) && rst_n_i;
    assign imem_addr_o   = pc_reg;
    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_reg + PC_STEP;
    assign instr_o       = instr_reg;
    assign instr_valid_o = (state_reg == S_VALID);
    assign misalign_o    = misalign_reg;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Directed bench for pc_fetch. The bench plays instruction memory and execute;
// expected values are hand-computed constants. Honours
// PC_FETCH_MISALIGN_TRAP_EN for the misaligned-target expectations.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_source;
    logic [31:0] target;
    logic        stall;
    logic        instr_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int check_cnt = 0;
    int error_cnt = 0;

    always #5 clk = ~clk;

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .TRAP_PC  (32'h0000_0100)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pc_source_i   (pc_source),
        .target_i      (target),
        .stall_i       (stall),
        .instr_ack_i   (instr_ack),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .misalign_o    (misalign)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    // Advance one cycle; inputs are then changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch from S_REQ. lat = 0: gnt and rvalid together;
    // otherwise gnt, then rvalid lat cycles later. Leaves DUT in S_VALID.
    task automatic fetch(input logic [31:0] data, input int lat);
        if (lat == 0) begin
            imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
            step();
            imem_gnt = 1'b0; imem_rvalid = 1'b0;
        end else begin
            imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0;
            repeat (lat - 1) begin
                check("wait_valid_low", 32'(instr_valid), 32'h0);
                step();
            end
            imem_rvalid = 1'b1; imem_rdata = data;
            step();
            imem_rvalid = 1'b0;
        end
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        instr_ack = 1'b1; pc_source = src; target = tgt;
        step();
        instr_ack = 1'b0; pc_source = 1'b0; target = '0;
    endtask

    initial begin
        rst_n = 1'b0; pc_source = 1'b0; target = '0; stall = 1'b0;
        instr_ack = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        step(); step();

        // Reset state
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);

        // 1: zero-wait fetch right after reset
        rst_n = 1'b1;
        #1;
        check("t1_req", 32'(imem_req), 32'h1);
        check("t1_addr", imem_addr, 32'h0);
        fetch(32'h0000_0013, 0);
        check("t1_valid", 32'(instr_valid), 32'h1);
        check("t1_instr", instr, 32'h0000_0013);
        check("t1_pc", pc, 32'h0);

        // rvalid in S_VALID is ignored
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("rvalid_ignored", instr, 32'h0000_0013);

        // 2: sequential, 3-cycle response
        retire(1'b0, 32'h0);
        check("t2_addr", imem_addr, 32'h4);
        check("t2_req", 32'(imem_req), 32'h1);
        check("t2_valid_low", 32'(instr_valid), 32'h0);
        // ack outside S_VALID is ignored
        instr_ack = 1'b1; pc_source = 1'b1; target = 32'h80;
        step();
        instr_ack = 1'b0; pc_source = 1'b0; target = '0;
        check("ack_ignored_pc", pc, 32'h4);
        check("req_held", 32'(imem_req), 32'h1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t2_wait_req", 32'(imem_req), 32'h0);
        check("t2_wait_valid", 32'(instr_valid), 32'h0);
        step();
        check("t2_wait2_valid", 32'(instr_valid), 32'h0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
        step();
        imem_rvalid = 1'b0;
        check("t2_valid", 32'(instr_valid), 32'h1);
        check("t2_instr", instr, 32'h0010_0093);
        check("t2_pc", pc, 32'h4);

        // 3: taken branch, then wrap
        retire(1'b1, 32'h40);
        check("t3_pc", pc, 32'h40);
        check("t3_addr", imem_addr, 32'h40);
        fetch(32'h1111_1111, 0);
        retire(1'b1, 32'hFFFF_FFFC);
        check("t3_pc_top", pc, 32'hFFFF_FFFC);
        check("t3_plus4_wrap", pc_plus4, 32'h0);
        fetch(32'h2222_2222, 1);
        retire(1'b0, 32'h0);
        check("t3_pc_wrap", pc, 32'h0);

        // 4: stall with ack held 5 cycles
        fetch(32'h3333_3333, 0);
        instr_ack = 1'b1; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_pc_hold", pc, 32'h0);
            check("t4_instr_hold", instr, 32'h3333_3333);
            check("t4_req_low", 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        step();
        instr_ack = 1'b0;
        check("t4_pc_adv", pc, 32'h4);
        check("t4_req", 32'(imem_req), 32'h1);

        // 5: misaligned taken target
        fetch(32'h4444_4444, 0);
        retire(1'b1, 32'h42);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        check("t5_pc_trap", pc, 32'h100);
        check("t5_misalign", 32'(misalign), 32'h1);
`else
        check("t5_pc_forced", pc, 32'h40);
        check("t5_misalign", 32'(misalign), 32'h0);
`endif
        step();
        check("t5_misalign_end", 32'(misalign), 32'h0);

        // 6: reset while in S_WAIT
        fetch(32'h5555_5555, 0);
        retire(1'b0, 32'h0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("t6_in_wait", 32'(imem_req), 32'h0);
        rst_n = 1'b0;
        step();
        check("t6_pc", pc, 32'h0);
        check("t6_valid", 32'(instr_valid), 32'h0);
        check("t6_req_in_rst", 32'(imem_req), 32'h0);
        rst_n = 1'b1;
        #1;
        check("t6_req", 32'(imem_req), 32'h1);
        check("t6_addr", imem_addr, 32'h0);
        fetch(32'h6666_6666, 2);
        check("t6_instr", instr, 32'h6666_6666);
        check("t6_valid_again", 32'(instr_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule : tb_pc_fetch
